// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced one-hot decoder: command mode
// encodings and the controller state type.
package decoder_pkg;

  // Command modes carried on the mode input
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

  // Controller states: IDLE accepts commands, SWEEP walks consecutive codes
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

endpackage : decoder_pkg

// File: rtl/onehot_dec.sv
// Purely combinational binary code to one-hot converter. Exactly one output
// bit is set for every input code.
module onehot_dec #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      code_i,
  output logic [(1<<IN_W)-1:0] onehot_o
);

  // Clear every strobe, then raise the one selected by the code
  always_comb begin
    onehot_o         = '0;
    onehot_o[code_i] = 1'b1;
  end

endmodule : onehot_dec

// File: rtl/decoder_nbit_seq.sv
// Registered binary to one-hot decoder with valid/ready handshakes on both
// sides. A SINGLE command produces one strobe beat; a SWEEP command walks
// consecutive codes (wrapping) for the requested number of beats. Only one
// beat is ever held, so a new command in IDLE can replace a consumed beat in
// the same cycle without a bubble.
module decoder_nbit_seq
  import decoder_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in,
  input  logic                 mode,
  input  logic [CNT_W-1:0]     len,
  output logic [(1<<IN_W)-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int OUT_W = 1 << IN_W;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    code_q, code_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   dec_onehot;
  logic               accept;
  logic               out_hs;

  // Commands are taken only in IDLE when the held beat is free or leaving
  assign in_ready  = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_SWEEP);

  // Decode the code that will be presented next, so the strobe is registered
  onehot_dec #(
    .IN_W (IN_W)
  ) u_onehot_dec (
    .code_i   (code_d),
    .onehot_o (dec_onehot)
  );

  // Next-state logic: new command wins, otherwise advance or retire on a
  // consumed beat; with no handshake everything is held (backpressure)
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      code_d      = in;
      out_valid_d = 1'b1;
      if ((mode == MODE_SWEEP) && (len > CNT_W'(1))) begin
        rem_d   = len - 1'b1;
        state_d = ST_SWEEP;
      end else begin
        rem_d   = '0;
        state_d = ST_IDLE;
      end
    end else if (out_hs) begin
      if ((state_q == ST_SWEEP) && (rem_q != '0)) begin
        code_d = code_q + 1'b1;
        rem_d  = rem_q - 1'b1;
      end else begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    end
    out_d = out_valid_d ? dec_onehot : '0;
  end

  // State and output registers with synchronous reset that aborts any sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      rem_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      rem_q       <= rem_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule : decoder_nbit_seq
